// File: rtl/ttt_pkg.sv
// Shared encodings, FSM states and win-line table for the tic-tac-toe turn controller
// and any other logic that needs to inspect the recorder grid.
package ttt_pkg;

  typedef enum logic [1:0] {
    GS_IDLE = 2'b00,
    GS_PLAY = 2'b01,
    GS_OVER = 2'b10
  } game_state_t;

  typedef enum logic [1:0] {
    MK_NONE = 2'b00,
    MK_O    = 2'b01,
    MK_X    = 2'b10
  } mark_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_O    = 2'b01;
  localparam logic [1:0] WIN_X    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ISSUE,
    S_CHECK,
    S_OVER
  } state_t;

  localparam int unsigned NUM_LINES = 8;

  // Rows, columns, then the two diagonals.
  localparam logic [3:0] LINE_TBL [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  function automatic logic [1:0] cell_at(input logic [17:0] g, input logic [3:0] idx);
    return g[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/ttt_turn_controller_if.sv
// Player-input, recorder-grid and status signals exchanged with the turn controller.
interface ttt_turn_controller_if;
  logic        start;
  logic        confirm;
  logic [3:0]  sel_pos;
  logic [17:0] grid;
  logic [1:0]  game_state;
  logic        whos_turn;
  logic [1:0]  mark;
  logic [3:0]  position;
  logic        invalid;
  logic        timeout;
  logic [1:0]  winner;
  logic [7:0]  move_cnt;

  modport master (
    output start, confirm, sel_pos, grid,
    input  game_state, whos_turn, mark, position, invalid, timeout, winner, move_cnt
  );

  modport slave (
    input  start, confirm, sel_pos, grid,
    output game_state, whos_turn, mark, position, invalid, timeout, winner, move_cnt
  );
endinterface

// File: rtl/ttt_line_checker.sv
// Combinational three-in-a-row detector over the 9-cell recorder grid.
module ttt_line_checker
  import ttt_pkg::*;
(
  input  logic [17:0] grid,
  output logic        x_win,
  output logic        o_win
);

  always_comb begin
    x_win = 1'b0;
    o_win = 1'b0;
    for (int unsigned l = 0; l < NUM_LINES; l++) begin
      if (cell_at(grid, LINE_TBL[l][0]) == MK_X &&
          cell_at(grid, LINE_TBL[l][1]) == MK_X &&
          cell_at(grid, LINE_TBL[l][2]) == MK_X)
        x_win = 1'b1;
      if (cell_at(grid, LINE_TBL[l][0]) == MK_O &&
          cell_at(grid, LINE_TBL[l][1]) == MK_O &&
          cell_at(grid, LINE_TBL[l][2]) == MK_O)
        o_win = 1'b1;
    end
  end

endmodule

// File: rtl/ttt_turn_controller.sv
// Turn sequencer: validates moves, issues one-cycle mark commands, detects win/draw
// and enforces the per-turn timeout.
module ttt_turn_controller
  import ttt_pkg::*;
#(
  parameter int unsigned TURN_TIMEOUT = 50_000_000,
  parameter int unsigned MAX_MOVES    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  ttt_turn_controller_if.slave  bus
);

  localparam int unsigned     TW         = (TURN_TIMEOUT == 0) ? 1 : $clog2(TURN_TIMEOUT + 1);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TURN_TIMEOUT - 1);
  localparam bit              TIMEOUT_EN = (TURN_TIMEOUT != 0);
  localparam bit              DRAW_EN    = (MAX_MOVES != 0);

  state_t      state_q, state_d;
  game_state_t game_state_q, game_state_d;
  mark_t       mark_q, mark_d;
  logic        whos_turn_q, whos_turn_d;
  logic [3:0]  position_q, position_d;
  logic        invalid_q, invalid_d;
  logic        timeout_q, timeout_d;
  logic [1:0]  winner_q, winner_d;
  logic [7:0]  move_cnt_q, move_cnt_d;
  logic [TW-1:0] timer_q, timer_d;

  logic x_win, o_win;
  logic sel_ok;
  logic timer_last;

  ttt_line_checker u_line_checker (
    .grid  (bus.grid),
    .x_win (x_win),
    .o_win (o_win)
  );

  assign sel_ok     = (bus.sel_pos <= 4'd8) && (cell_at(bus.grid, bus.sel_pos) == MK_NONE);
  assign timer_last = TIMEOUT_EN && (timer_q == TIMER_LAST);

  always_comb begin
    state_d      = state_q;
    game_state_d = game_state_q;
    mark_d       = MK_NONE;
    whos_turn_d  = whos_turn_q;
    position_d   = position_q;
    invalid_d    = 1'b0;
    timeout_d    = 1'b0;
    winner_d     = winner_q;
    move_cnt_d   = move_cnt_q;
    timer_d      = timer_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d      = S_WAIT;
          game_state_d = GS_PLAY;
          timer_d      = '0;
        end
      end

      S_WAIT: begin
        // Terminal count always clears the timer (even on a rejected confirm) so it never wraps.
        if (TIMEOUT_EN)
          timer_d = timer_last ? '0 : timer_q + 1'b1;
        if (bus.confirm) begin
          if (sel_ok) begin
            // Mark and count are registered here so they are visible during S_ISSUE.
            state_d    = S_ISSUE;
            position_d = bus.sel_pos;
            mark_d     = whos_turn_q ? MK_X : MK_O;
            move_cnt_d = (move_cnt_q == 8'hFF) ? move_cnt_q : move_cnt_q + 8'd1;
            timer_d    = '0;
          end else begin
            invalid_d = 1'b1;
          end
        end else if (timer_last) begin
          timeout_d   = 1'b1;
          whos_turn_d = ~whos_turn_q;
        end
      end

      S_ISSUE: state_d = S_CHECK;

      S_CHECK: begin
        if (x_win) begin
          winner_d     = WIN_X;
          state_d      = S_OVER;
          game_state_d = GS_OVER;
        end else if (o_win) begin
          winner_d     = WIN_O;
          state_d      = S_OVER;
          game_state_d = GS_OVER;
        end else if (DRAW_EN && (32'(move_cnt_q) == MAX_MOVES)) begin
          winner_d     = WIN_DRAW;
          state_d      = S_OVER;
          game_state_d = GS_OVER;
        end else begin
          whos_turn_d = ~whos_turn_q;
          state_d     = S_WAIT;
          timer_d     = '0;
        end
      end

      S_OVER: ;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      game_state_q <= GS_IDLE;
      mark_q       <= MK_NONE;
      whos_turn_q  <= 1'b1;
      position_q   <= '0;
      invalid_q    <= 1'b0;
      timeout_q    <= 1'b0;
      winner_q     <= WIN_NONE;
      move_cnt_q   <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      game_state_q <= game_state_d;
      mark_q       <= mark_d;
      whos_turn_q  <= whos_turn_d;
      position_q   <= position_d;
      invalid_q    <= invalid_d;
      timeout_q    <= timeout_d;
      winner_q     <= winner_d;
      move_cnt_q   <= move_cnt_d;
      timer_q      <= timer_d;
    end
  end

  assign bus.game_state = game_state_q;
  assign bus.whos_turn  = whos_turn_q;
  assign bus.mark       = mark_q;
  assign bus.position   = position_q;
  assign bus.invalid    = invalid_q;
  assign bus.timeout    = timeout_q;
  assign bus.winner     = winner_q;
  assign bus.move_cnt   = move_cnt_q;

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Scoreboard bench: dut_a uses the default timeout for normal play, dut_b uses a short
// timeout and a 4-move draw limit.
module tb_ttt_turn_controller;
  import ttt_pkg::*;

  typedef struct packed {
    logic [1:0] mark;
    logic [3:0] pos;
    logic       inv;
    logic       tmo;
    logic [7:0] cnt;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  ttt_turn_controller_if bus_a ();
  ttt_turn_controller_if bus_b ();

  ttt_turn_controller #(.TURN_TIMEOUT(50_000_000), .MAX_MOVES(0)) dut_a (
    .clk (clk), .rst (rst_a), .bus (bus_a)
  );

  ttt_turn_controller #(.TURN_TIMEOUT(8), .MAX_MOVES(4)) dut_b (
    .clk (clk), .rst (rst_b), .bus (bus_b)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  rsp_t exp_a[$];
  rsp_t exp_b[$];
  rsp_t mon_a, mon_b, want_a, want_b;

  // Recorder models: commit the mark on the edge that ends S_ISSUE.
  always @(posedge clk or negedge rst_a)
    if (!rst_a) bus_a.grid <= '0;
    else if (bus_a.mark != 2'b00) bus_a.grid[{bus_a.position, 1'b0} +: 2] <= bus_a.mark;

  always @(posedge clk or negedge rst_b)
    if (!rst_b) bus_b.grid <= '0;
    else if (bus_b.mark != 2'b00) bus_b.grid[{bus_b.position, 1'b0} +: 2] <= bus_b.mark;

  function automatic rsp_t rsp(input logic [1:0] m, input logic [3:0] p, input logic i,
                               input logic t, input logic [7:0] c);
    rsp_t r;
    r.mark = m; r.pos = p; r.inv = i; r.tmo = t; r.cnt = c;
    return r;
  endfunction

  // Monitor: any mark/invalid/timeout pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (bus_a.mark != 2'b00 || bus_a.invalid || bus_a.timeout) begin
      mon_a = rsp(bus_a.mark, bus_a.position, bus_a.invalid, bus_a.timeout, bus_a.move_cnt);
      n_checks++;
      if (exp_a.size() == 0) begin
        n_errors++;
        $display("FAIL dut_a_event: got %h, required no event", mon_a);
      end else begin
        want_a = exp_a.pop_front();
        if (mon_a !== want_a) begin
          n_errors++;
          $display("FAIL dut_a_event: got %h, required %h", mon_a, want_a);
        end
      end
    end
    if (bus_b.mark != 2'b00 || bus_b.invalid || bus_b.timeout) begin
      mon_b = rsp(bus_b.mark, bus_b.position, bus_b.invalid, bus_b.timeout, bus_b.move_cnt);
      n_checks++;
      if (exp_b.size() == 0) begin
        n_errors++;
        $display("FAIL dut_b_event: got %h, required no event", mon_b);
      end else begin
        want_b = exp_b.pop_front();
        if (mon_b !== want_b) begin
          n_errors++;
          $display("FAIL dut_b_event: got %h, required %h", mon_b, want_b);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [12:0] status(input int id);
    if (id == 0) return {bus_a.game_state, bus_a.whos_turn, bus_a.winner, bus_a.move_cnt};
    return {bus_b.game_state, bus_b.whos_turn, bus_b.winner, bus_b.move_cnt};
  endfunction

  task automatic chk_status(input string tag, input int id, input logic [1:0] gs,
                            input logic wt, input logic [1:0] win, input logic [7:0] cnt);
    logic [12:0] s;
    s = status(id);
    chk({tag, ".game_state"}, 32'(s[12:11]), 32'(gs));
    chk({tag, ".whos_turn"},  32'(s[10]),    32'(wt));
    chk({tag, ".winner"},     32'(s[9:8]),   32'(win));
    chk({tag, ".move_cnt"},   32'(s[7:0]),   32'(cnt));
  endtask

  task automatic steps(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_confirm(input int id, input logic [3:0] p);
    if (id == 0) begin bus_a.confirm = 1'b1; bus_a.sel_pos = p; end
    else         begin bus_b.confirm = 1'b1; bus_b.sel_pos = p; end
    @(negedge clk);
    if (id == 0) bus_a.confirm = 1'b0;
    else         bus_b.confirm = 1'b0;
  endtask

  task automatic do_start(input int id);
    if (id == 0) bus_a.start = 1'b1;
    else         bus_b.start = 1'b1;
    @(negedge clk);
    if (id == 0) bus_a.start = 1'b0;
    else         bus_b.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  initial begin
    bus_a.start = 1'b0; bus_a.confirm = 1'b0; bus_a.sel_pos = '0;
    bus_b.start = 1'b0; bus_b.confirm = 1'b0; bus_b.sel_pos = '0;
    rst_a = 1'b1; rst_b = 1'b1;
    #1 rst_a = 1'b0; rst_b = 1'b0;
    #2;
    chk_status("reset_a", 0, GS_IDLE, 1'b1, WIN_NONE, 8'd0);
    chk_status("reset_b", 1, GS_IDLE, 1'b1, WIN_NONE, 8'd0);
    chk("reset_a.mark",     32'(bus_a.mark),     32'd0);
    chk("reset_a.position", 32'(bus_a.position), 32'd0);
    chk("reset_a.invalid",  32'(bus_a.invalid),  32'd0);
    chk("reset_a.timeout",  32'(bus_a.timeout),  32'd0);
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;

    // 1: opening moves, turn alternation
    do_start(0);
    chk_status("t1_start", 0, GS_PLAY, 1'b1, WIN_NONE, 8'd0);
    exp_a.push_back(rsp(MK_X, 4'd4, 1'b0, 1'b0, 8'd1));
    do_confirm(0, 4'd4);
    steps(2);
    chk_status("t1_after_x", 0, GS_PLAY, 1'b0, WIN_NONE, 8'd1);
    exp_a.push_back(rsp(MK_O, 4'd0, 1'b0, 1'b0, 8'd2));
    do_confirm(0, 4'd0);
    steps(2);
    chk_status("t1_after_o", 0, GS_PLAY, 1'b1, WIN_NONE, 8'd2);

    // 2: occupied cell on O's turn
    exp_a.push_back(rsp(MK_X, 4'd8, 1'b0, 1'b0, 8'd3));
    do_confirm(0, 4'd8);
    steps(2);
    exp_a.push_back(rsp(MK_NONE, 4'd8, 1'b1, 1'b0, 8'd3));
    do_confirm(0, 4'd4);
    steps(1);
    chk_status("t2_occupied", 0, GS_PLAY, 1'b0, WIN_NONE, 8'd3);

    // 3: out-of-range cursor, two back-to-back confirms
    exp_a.push_back(rsp(MK_NONE, 4'd8, 1'b1, 1'b0, 8'd3));
    exp_a.push_back(rsp(MK_NONE, 4'd8, 1'b1, 1'b0, 8'd3));
    do_confirm(0, 4'd9);
    do_confirm(0, 4'd15);
    steps(1);
    chk_status("t3_range", 0, GS_PLAY, 1'b0, WIN_NONE, 8'd3);

    // 4: fresh game, X wins on the top row; confirms during ISSUE/CHECK are dropped
    rst_a = 1'b0;
    #1 chk("t4_reset.position", 32'(bus_a.position), 32'd0);
    @(negedge clk);
    rst_a = 1'b1;
    do_start(0);
    exp_a.push_back(rsp(MK_X, 4'd0, 1'b0, 1'b0, 8'd1));
    do_confirm(0, 4'd0);
    do_confirm(0, 4'd5);
    do_confirm(0, 4'd6);
    chk_status("t4_dropped", 0, GS_PLAY, 1'b0, WIN_NONE, 8'd1);
    exp_a.push_back(rsp(MK_O, 4'd3, 1'b0, 1'b0, 8'd2));
    do_confirm(0, 4'd3);
    steps(2);
    exp_a.push_back(rsp(MK_X, 4'd1, 1'b0, 1'b0, 8'd3));
    do_confirm(0, 4'd1);
    steps(2);
    exp_a.push_back(rsp(MK_O, 4'd4, 1'b0, 1'b0, 8'd4));
    do_confirm(0, 4'd4);
    steps(2);
    exp_a.push_back(rsp(MK_X, 4'd2, 1'b0, 1'b0, 8'd5));
    do_confirm(0, 4'd2);
    steps(2);
    chk_status("t4_win", 0, GS_OVER, 1'b1, WIN_X, 8'd5);
    do_confirm(0, 4'd5);
    do_start(0);
    steps(3);
    chk_status("t4_over_hold", 0, GS_OVER, 1'b1, WIN_X, 8'd5);

    // 5: confirm ignored in IDLE, then timeout and confirm-on-terminal-cycle
    do_confirm(1, 4'd4);
    chk_status("t5_idle", 1, GS_IDLE, 1'b1, WIN_NONE, 8'd0);
    do_start(1);
    exp_b.push_back(rsp(MK_NONE, 4'd0, 1'b0, 1'b1, 8'd0));
    steps(7);
    chk("t5_no_early_timeout", 32'(bus_b.timeout), 32'd0);
    steps(1);
    chk("t5_timeout", 32'(bus_b.timeout), 32'd1);
    chk("t5_timeout.whos_turn", 32'(bus_b.whos_turn), 32'd0);
    steps(7);
    exp_b.push_back(rsp(MK_O, 4'd4, 1'b0, 1'b0, 8'd1));
    do_confirm(1, 4'd4);
    chk("t5_timeout_suppressed", 32'(bus_b.timeout), 32'd0);
    steps(2);
    chk_status("t5_after_move", 1, GS_PLAY, 1'b1, WIN_NONE, 8'd1);

    // 6: draw at MAX_MOVES, then reset while in S_ISSUE
    exp_b.push_back(rsp(MK_X, 4'd0, 1'b0, 1'b0, 8'd2));
    do_confirm(1, 4'd0);
    steps(2);
    exp_b.push_back(rsp(MK_O, 4'd8, 1'b0, 1'b0, 8'd3));
    do_confirm(1, 4'd8);
    steps(2);
    exp_b.push_back(rsp(MK_X, 4'd2, 1'b0, 1'b0, 8'd4));
    do_confirm(1, 4'd2);
    steps(2);
    chk_status("t6_draw", 1, GS_OVER, 1'b1, WIN_DRAW, 8'd4);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    do_start(1);
    exp_b.push_back(rsp(MK_X, 4'd4, 1'b0, 1'b0, 8'd1));
    do_confirm(1, 4'd4);
    #2 rst_b = 1'b0;
    #1;
    chk_status("t6_abort", 1, GS_IDLE, 1'b1, WIN_NONE, 8'd0);
    chk("t6_abort.mark",     32'(bus_b.mark),     32'd0);
    chk("t6_abort.position", 32'(bus_b.position), 32'd0);
    @(negedge clk);
    chk("t6_abort.grid", 32'(bus_b.grid), 32'd0);
    rst_b = 1'b1;

    steps(2);
    chk("queue_a_drained", 32'(exp_a.size()), 32'd0);
    chk("queue_b_drained", 32'(exp_b.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
